vga_ctrlmod: RTL

Pixel-rendering stage directly downstream of the 1024×768@60 Hz sync generator `vga_funcmod`. It takes the raw horizontal/vertical counter pair `{X, Y}` from that generator and decodes the visible area. It draws one 128×128 RGB565 image from a synchronous ROM at a frame-latched position over a solid background. RGB is produced with exactly 3 cycles of latency, so it lines up with the generator's 3-stage-delayed HSYNC/VSYNC.

---
 rtl/vga_ctrlmod.sv | 107 ++++++++++
 1 files changed

// File: rtl/vga_ctrlmod.sv
`timescale 1ns/1ps
// vga_ctrlmod: decodes the visible area from the sync generator's raw {X,Y} counters
// and renders a 128x128 RGB565 ROM image over a solid background, 3-cycle latency.
module vga_ctrlmod #(
    parameter int unsigned XOFF  = 296,
    parameter int unsigned YOFF  = 35,
    parameter int unsigned XSIZE = 1024,
    parameter int unsigned YSIZE = 768,
    parameter logic [15:0] BG    = 16'h001F
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [20:0] iAddr,
    input  logic [10:0] iPosX,
    input  logic [9:0]  iPosY,
    output logic [13:0] oRomAddr,
    input  logic [15:0] iRomData,
    output logic [4:0]  VGA_RED,
    output logic [5:0]  VGA_GREEN,
    output logic [4:0]  VGA_BLUE,
    output logic        oFrame
);

    localparam logic [10:0] X_LO  = 11'(XOFF);
    localparam logic [10:0] X_HI  = 11'(XOFF + XSIZE);
    localparam logic [9:0]  Y_LO  = 10'(YOFF);
    localparam logic [9:0]  Y_HI  = 10'(YOFF + YSIZE);
    localparam logic [11:0] IMG_W = 12'd128;
    localparam logic [10:0] IMG_H = 11'd128;

    logic [10:0] cnt_x;
    logic [9:0]  cnt_y;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [10:0] s_x;
    logic [9:0]  s_y;
    logic        frame_start;
    logic        vis;
    logic        in_x;
    logic        in_y;
    logic        img;
    logic [6:0]  col;
    logic [6:0]  row;
    logic        vis1;
    logic        img1;
    logic        vis2;
    logic        img2;
    logic [15:0] colour;

    // Stage-0 decode: visible window, then image window against the frame shadows.
    always_comb begin
        cnt_x       = iAddr[20:10];
        cnt_y       = iAddr[9:0];
        frame_start = (iAddr == 21'd0);
        vis         = (cnt_x >= X_LO) && (cnt_x < X_HI) && (cnt_y >= Y_LO) && (cnt_y < Y_HI);
        pix_x       = cnt_x - X_LO;
        pix_y       = cnt_y - Y_LO;
        // One extra bit on the upper bound so an image near the right/bottom edge never wraps.
        in_x        = (pix_x >= s_x) && ({1'b0, pix_x} < ({1'b0, s_x} + IMG_W));
        in_y        = (pix_y >= s_y) && ({1'b0, pix_y} < ({1'b0, s_y} + IMG_H));
        img         = vis && in_x && in_y;
        col         = 7'(pix_x - s_x);
        row         = 7'(pix_y - s_y);
    end

    // Stage-3 colour select; blanking must be black, not background.
    always_comb begin
        colour = 16'h0000;
        if (img2) begin
            colour = iRomData;
        end else if (vis2) begin
            colour = BG;
        end
    end

    // NOTE: every register here uses non-blocking assignment so all stages advance on the same edge.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            s_x       <= '0;
            s_y       <= '0;
            oFrame    <= 1'b0;
            oRomAddr  <= '0;
            vis1      <= 1'b0;
            img1      <= 1'b0;
            vis2      <= 1'b0;
            img2      <= 1'b0;
            VGA_RED   <= '0;
            VGA_GREEN <= '0;
            VGA_BLUE  <= '0;
        end else begin
            oFrame <= frame_start;
            if (frame_start) begin
                s_x <= iPosX;
                s_y <= iPosY;
            end
            vis1 <= vis;
            img1 <= img;
            if (img) begin
                oRomAddr <= {row, col};
            end
            vis2 <= vis1;
            img2 <= img1;
            {VGA_RED, VGA_GREEN, VGA_BLUE} <= colour;
        end
    end

endmodule
